// File: rtl/biu_arb_pkg.sv
// ============================================================================
// Module      : biu_arb_pkg
// Description : Shared types and helpers for the BIU round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package biu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Grant index width; never narrower than one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin pick: first pending channel after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int GW          = 2
) (
    input  logic [NUM_MASTERS-1:0] pending,
    input  logic [GW-1:0]          last_grant,
    output logic [GW-1:0]          grant,
    output logic                   valid
);

    logic [2*NUM_MASTERS-1:0] dbl;
    logic [2*NUM_MASTERS-1:0] mask;

    // Doubling the vector lets a single lowest-bit search wrap past the top channel.
    always_comb begin
        dbl   = {pending, pending};
        mask  = '0;
        grant = '0;
        for (int j = 0; j < 2*NUM_MASTERS; j++) begin
            mask[j] = (j > int'(last_grant));
        end
        for (int j = 2*NUM_MASTERS-1; j >= 0; j--) begin
            if (dbl[j] && mask[j]) begin
                grant = GW'(j % NUM_MASTERS);
            end
        end
    end

    assign valid = |pending;

endmodule

`default_nettype wire

// File: rtl/biu_rr_arbiter.sv
// ============================================================================
// Module      : biu_rr_arbiter
// Description : Round-robin arbiter serialising NUM_MASTERS BIU masters onto one slave.
//               Optional WAIT timeout enabled by defining BIU_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biu_rr_arbiter
    import biu_arb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          NUM_MASTERS    = 4,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [63:0] TIMEOUT_DATA   = 64'hDEADBEEF
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
    input  logic [NUM_MASTERS-1:0]            m_rnw,
    input  logic [NUM_MASTERS-1:0]            m_en,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
    output logic [NUM_MASTERS-1:0]            m_data_valid,
    output logic [NUM_MASTERS-1:0]            m_busy,
    output logic [ADDR_WIDTH-1:0]             s_address,
    output logic [DATA_WIDTH-1:0]             s_data_in,
    output logic                              s_rnw,
    output logic                              s_en,
    input  logic [DATA_WIDTH-1:0]             s_data_out,
    input  logic                              s_data_valid,
    output logic [NUM_MASTERS-1:0]            timeout_err
);

    localparam int GW = grant_width(NUM_MASTERS);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  rnw;
    } req_t;

    arb_state_t                 state;
    arb_state_t                 state_nxt;
    req_t [NUM_MASTERS-1:0]     req_vec;
    logic [NUM_MASTERS-1:0]     pending;
    logic [NUM_MASTERS-1:0]     accept;
    logic [NUM_MASTERS-1:0]     done_vec;
    logic [NUM_MASTERS-1:0]     valid_q;
    logic [GW-1:0]              grant;
    logic [GW-1:0]              last_grant;
    logic [GW-1:0]              pick_grant;
    logic                       pick_valid;
    logic                       complete;
    logic                       timed_out;
    logic [DATA_WIDTH-1:0]      resp_data;

    if (NUM_MASTERS < 2) begin : g_bad_num_masters
        $error("biu_rr_arbiter: NUM_MASTERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("biu_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .GW          (GW)
    ) u_picker (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // A request is only accepted while the channel is idle; en during busy is dropped.
    assign accept    = m_en & ~pending;
    assign complete  = (state == WAIT) && (s_data_valid || timed_out);
    assign done_vec  = complete ? (NUM_MASTERS'(1) << grant) : '0;
    assign resp_data = timed_out ? DATA_WIDTH'(TIMEOUT_DATA) : s_data_out;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ch
        req_t                  req_r;
        logic [DATA_WIDTH-1:0] rdata_r;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                req_r   <= '0;
                rdata_r <= '0;
            end else begin
                if (accept[i]) begin
                    req_r <= '{addr: m_address[i*ADDR_WIDTH +: ADDR_WIDTH],
                               data: m_data_out[i*DATA_WIDTH +: DATA_WIDTH],
                               rnw:  m_rnw[i]};
                end
                if (done_vec[i] && s_rnw) begin
                    rdata_r <= resp_data;
                end
            end
        end

        assign req_vec[i]                              = req_r;
        assign m_data_in[i*DATA_WIDTH +: DATA_WIDTH]   = rdata_r;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (complete) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_en = 1'b0;
        if (state == ISSUE) begin
            s_en = 1'b1;
        end
    end

    // Slave-side fields are loaded with the grant and stay stable through WAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            s_address  <= '0;
            s_data_in  <= '0;
            s_rnw      <= 1'b0;
            pending    <= '0;
            valid_q    <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                grant     <= pick_grant;
                s_address <= req_vec[pick_grant].addr;
                s_data_in <= req_vec[pick_grant].data;
                s_rnw     <= req_vec[pick_grant].rnw;
            end
            if (complete) begin
                last_grant <= grant;
            end
            pending <= (pending | accept) & ~done_vec;
            valid_q <= done_vec;
        end
    end

    assign m_busy       = pending;
    assign m_data_valid = valid_q;

`ifdef BIU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // Loaded as WAIT is entered; expiry is the cycle the count would reach zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt     <= '0;
            timeout_err <= '0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= CW'(TIMEOUT_CYCLES);
            end else if (state == WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - CW'(1);
            end
            timeout_err <= timed_out ? done_vec : '0;
        end
    end

    assign timed_out = (state == WAIT) && !s_data_valid && (tmo_cnt <= CW'(1));
`else
    assign timed_out   = 1'b0;
    assign timeout_err = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (!(|(m_en & m_busy)))
                else $error("biu_rr_arbiter: en asserted on a busy channel");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_biu_rr_arbiter.sv
// ============================================================================
// Module      : tb_biu_rr_arbiter
// Description : Directed self-checking bench for biu_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_biu_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk   = 1'b0;
    logic              n_rst = 1'b0;
    logic [NM*AW-1:0]  m_address  = '0;
    logic [NM*DW-1:0]  m_data_out = '0;
    logic [NM-1:0]     m_rnw      = '0;
    logic [NM-1:0]     m_en       = '0;
    logic [NM*DW-1:0]  m_data_in;
    logic [NM-1:0]     m_data_valid;
    logic [NM-1:0]     m_busy;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_data_in;
    logic              s_rnw;
    logic              s_en;
    logic [DW-1:0]     s_data_out   = '0;
    logic              s_data_valid = 1'b0;
    logic [NM-1:0]     timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    biu_rr_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_DATA   (64'hDEADBEEF)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .m_address    (m_address),
        .m_data_out   (m_data_out),
        .m_rnw        (m_rnw),
        .m_en         (m_en),
        .m_data_in    (m_data_in),
        .m_data_valid (m_data_valid),
        .m_busy       (m_busy),
        .s_address    (s_address),
        .s_data_in    (s_data_in),
        .s_rnw        (s_rnw),
        .s_en         (s_en),
        .s_data_out   (s_data_out),
        .s_data_valid (s_data_valid),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        int          ch;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] din(input int ch);
        return m_data_in[ch*DW +: DW];
    endfunction

    function automatic logic [31:0] ch_addr(input int ch);
        return 32'h1000 + 32'(ch) * 32'h10;
    endfunction

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rnw);
        m_address[ch*AW +: AW]  = addr;
        m_data_out[ch*DW +: DW] = wdata;
        m_rnw[ch]               = rnw;
        m_en[ch]                = 1'b1;
    endtask

    task automatic wait_s_en(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            m_en = '0;
            if (s_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL s_en_wait: got no s_en within %0d cycles, required s_en=1", limit);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " data_in"},    m_data_in,    '0);
        chk({tag, " data_valid"}, m_data_valid, '0);
        chk({tag, " busy"},       m_busy,       '0);
        chk({tag, " s_en"},       s_en,         '0);
        chk({tag, " s_address"},  s_address,    '0);
        chk({tag, " s_data_in"},  s_data_in,    '0);
        chk({tag, " s_rnw"},      s_rnw,        '0);
        chk({tag, " timeout_err"}, timeout_err, '0);
    endtask

    task automatic do_reset();
        m_en         = '0;
        s_data_valid = 1'b0;
        n_rst        = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_1234, 1, 32'h0000_1234};
        vecs[1] = '{1, 1'b0, 32'h0000_0204, 32'h0000_A5A5, 32'h0000_7777, 2, 32'h0};
        vecs[2] = '{2, 1'b1, 32'h0000_0308, 32'h0,         32'hCAFE_F00D, 3, 32'hCAFE_F00D};
        vecs[3] = '{3, 1'b1, 32'h0000_040C, 32'h0000_0042, 32'h0BAD_F00D, 1, 32'h0BAD_F00D};
        vecs[4] = '{2, 1'b0, 32'h0000_0310, 32'h0000_1111, 32'h0000_9999, 1, 32'hCAFE_F00D};
        vecs[5] = '{0, 1'b1, 32'h0000_0104, 32'h0,         32'hFFFF_FFFF, 1, 32'hFFFF_FFFF};

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Single transactions, one channel at a time
        foreach (vecs[v]) begin
            logic [NM-1:0] onehot;
            onehot = NM'(1) << vecs[v].ch;
            set_req(vecs[v].ch, vecs[v].addr, vecs[v].wdata, vecs[v].rnw);
            @(negedge clk);
            m_en = '0;
            chk($sformatf("v%0d busy@N+1", v), m_busy, onehot);
            chk($sformatf("v%0d s_en@N+1", v), s_en, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d s_en@N+2", v), s_en, 1'b1);
            chk($sformatf("v%0d s_address", v), s_address, vecs[v].addr);
            chk($sformatf("v%0d s_rnw", v), s_rnw, vecs[v].rnw);
            chk($sformatf("v%0d s_data_in", v), s_data_in, vecs[v].wdata);
            chk($sformatf("v%0d busy@N+2", v), m_busy, onehot);
            for (int k = 1; k < vecs[v].delay; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d s_en wait", v), s_en, 1'b0);
                chk($sformatf("v%0d dv wait", v), m_data_valid, '0);
            end
            @(negedge clk);
            chk($sformatf("v%0d busy@resp", v), m_busy, onehot);
            chk($sformatf("v%0d s_address held", v), s_address, vecs[v].addr);
            s_data_out   = vecs[v].rdata;
            s_data_valid = 1'b1;
            @(negedge clk);
            s_data_valid = 1'b0;
            chk($sformatf("v%0d data_valid", v), m_data_valid, onehot);
            chk($sformatf("v%0d busy done", v), m_busy, '0);
            chk($sformatf("v%0d data_in", v), din(vecs[v].ch), vecs[v].exp_din);
            chk($sformatf("v%0d timeout_err", v), timeout_err, '0);
            @(negedge clk);
            chk($sformatf("v%0d dv pulse", v), m_data_valid, '0);
        end

        // Four simultaneous writes: served 0,1,2,3 from reset priority
        do_reset();
        for (int ch = 0; ch < NM; ch++) set_req(ch, ch_addr(ch), 32'hA000 + 32'(ch), 1'b0);
        for (int k = 0; k < NM; k++) begin
            logic [NM-1:0] left;
            left = NM'(4'hF << (k + 1));
            wait_s_en(12);
            chk($sformatf("all4 grant%0d addr", k), s_address, ch_addr(k));
            chk($sformatf("all4 grant%0d wdata", k), s_data_in, 32'hA000 + 32'(k));
            @(negedge clk);
            s_data_out   = 32'hBAD0 + 32'(k);
            s_data_valid = 1'b1;
            @(negedge clk);
            s_data_valid = 1'b0;
            chk($sformatf("all4 dv%0d", k), m_data_valid, NM'(1) << k);
            chk($sformatf("all4 busy%0d", k), m_busy, left);
            chk($sformatf("all4 s_en idle%0d", k), s_en, 1'b0);
            chk($sformatf("all4 write keeps din%0d", k), din(k), '0);
        end

        // ch1 and ch2 keep re-requesting: grants must alternate
        set_req(1, ch_addr(1), 32'h0, 1'b1);
        set_req(2, ch_addr(2), 32'h0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            int ch;
            ch = (k % 2 == 0) ? 1 : 2;
            wait_s_en(12);
            chk($sformatf("alt grant%0d", k), s_address, ch_addr(ch));
            @(negedge clk);
            s_data_out   = 32'h3000 + 32'(k);
            s_data_valid = 1'b1;
            @(negedge clk);
            s_data_valid = 1'b0;
            chk($sformatf("alt dv%0d", k), m_data_valid, NM'(1) << ch);
            chk($sformatf("alt din%0d", k), din(ch), 32'h3000 + 32'(k));
            if (k < 4) m_en[ch] = 1'b1;
        end

        // Reset while ch3 read is waiting on the slave
        @(negedge clk);
        set_req(3, ch_addr(3), 32'h0, 1'b1);
        wait_s_en(12);
        chk("rst grant ch3", s_address, ch_addr(3));
        @(negedge clk);
        chk("rst busy ch3", m_busy, 4'b1000);
        n_rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        n_rst = 1'b1;
        @(negedge clk);
        set_req(0, ch_addr(0), 32'h0, 1'b1);
        wait_s_en(12);
        chk("after rst grant ch0", s_address, ch_addr(0));
        @(negedge clk);
        s_data_out   = 32'h4444;
        s_data_valid = 1'b1;
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("after rst dv only ch0", m_data_valid, 4'b0001);
        chk("after rst din0", din(0), 32'h4444);
        chk("after rst busy", m_busy, '0);
        repeat (3) begin
            @(negedge clk);
            chk("after rst no stale dv", m_data_valid, '0);
        end

`ifdef BIU_ARB_TIMEOUT_EN
        // Slave never answers: forced completion after 8 WAIT cycles
        set_req(2, ch_addr(2), 32'h0, 1'b1);
        wait_s_en(12);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo wait%0d dv", k), m_data_valid, '0);
            chk($sformatf("tmo wait%0d err", k), timeout_err, '0);
        end
        @(negedge clk);
        chk("tmo dv", m_data_valid, 4'b0100);
        chk("tmo din", din(2), 32'hDEADBEEF);
        chk("tmo err", timeout_err, 4'b0100);
        chk("tmo busy", m_busy, '0);
        @(negedge clk);
        chk("tmo err pulse", timeout_err, '0);

        // Response on the expiry cycle wins
        set_req(1, ch_addr(1), 32'h0, 1'b1);
        wait_s_en(12);
        repeat (7) begin
            @(negedge clk);
            chk("late wait dv", m_data_valid, '0);
        end
        @(negedge clk);
        s_data_out   = 32'h5555;
        s_data_valid = 1'b1;
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("late dv", m_data_valid, 4'b0010);
        chk("late din", din(1), 32'h5555);
        chk("late err", timeout_err, '0);
`else
        // Without the timeout the slave may stall indefinitely
        set_req(2, ch_addr(2), 32'h0, 1'b1);
        wait_s_en(12);
        repeat (20) begin
            @(negedge clk);
            chk("stall dv", m_data_valid, '0);
            chk("stall busy", m_busy, 4'b0100);
        end
        s_data_out   = 32'h6666;
        s_data_valid = 1'b1;
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("stall dv", m_data_valid, 4'b0100);
        chk("stall din", din(2), 32'h6666);
        chk("stall err", timeout_err, '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
